// File: rtl/pms_i2c_slv_pkg.sv
// Shared definitions for the PMS I2C write-only slave: register offsets,
// status register bit positions and the bus protocol FSM state encoding.
package pms_i2c_slv_pkg;

    localparam logic [3:0] REG0_OFF = 4'h0;  // address / enable
    localparam logic [3:0] REG1_OFF = 4'h4;  // RX data (read pops)
    localparam logic [3:0] REG2_OFF = 4'h8;  // status, W1C flags
    localparam logic [3:0] REG3_OFF = 4'hC;  // interrupt enables

    localparam int R2_NEMPTY = 0;
    localparam int R2_FULL   = 1;
    localparam int R2_OVF    = 2;
    localparam int R2_STOP   = 3;
    localparam int R2_BUSY   = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } state_e;

endpackage

// File: rtl/pms_i2c_slv_irq_if.sv
// APB slave bus bundle for the PMS I2C slave. Member names keep the
// slave-side direction suffix so they read the same at the RTL boundary.
interface pms_i2c_slv_irq_if;
    logic [3:0]  paddr_i;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    modport master (
        output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  paddr_i, psel_i, penable_i, pwrite_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/pms_i2c_slv_fifo.sv
// Synchronous show-ahead FIFO holding received I2C bytes. A push while full
// is accepted only when a pop happens in the same cycle.
module pms_i2c_slv_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pms_i2c_slv_irq.sv
// PMS I2C write-only slave with APB register file, RX FIFO and level IRQ.
// SCL/SDA are oversampled in the SoC clock domain; no I2C clock is used.
module pms_i2c_slv_irq
    import pms_i2c_slv_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pms_i2c_slv_irq_if.slave  apb,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe_o,
    output logic              irq_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ---------------- input conditioning ----------------
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_new, scl_old, sda_new, sda_old;
    logic scl_rise, scl_fall, scl_high, start_det, stop_det;

    // Synchronisers reset to the idle-bus level so leaving reset creates no edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_new   = scl_sync_q[SYNC_STAGES-2];
    assign scl_old   = scl_sync_q[SYNC_STAGES-1];
    assign sda_new   = sda_sync_q[SYNC_STAGES-2];
    assign sda_old   = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_new & ~scl_old;
    assign scl_fall  = ~scl_new & scl_old;
    assign scl_high  = scl_new & scl_old;
    assign start_det = scl_high & sda_old & ~sda_new;
    assign stop_det  = scl_high & ~sda_old & sda_new;

    // ---------------- register file state ----------------
    logic [6:0] slv_addr_q;
    logic       en_q, ovf_q, stop_seen_q, irq_q;
    logic [1:0] irq_en_q;

    // ---------------- FIFO ----------------
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_rdata, rx_byte;
    logic [CNT_W-1:0] fifo_cnt;
    logic             rx_not_empty;

    pms_i2c_slv_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i (rx_byte),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign rx_not_empty = (fifo_cnt != '0);

    // ---------------- protocol FSM ----------------
    state_e     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [6:0] shift_q, shift_d;
    logic       ack_q, ack_d;        // currently pulling SDA low in an ACK slot
    logic       matched_q, matched_d; // last address phase addressed us
    logic       ovf_set, stop_set;

    assign rx_byte = {shift_q, sda_new};

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            ack_q     <= 1'b0;
            matched_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            ack_q     <= ack_d;
            matched_q <= matched_d;
        end
    end

    // Next-state logic: START/STOP override everything, START first.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        ack_d     = ack_q;
        matched_d = matched_q;
        fifo_push = 1'b0;
        ovf_set   = 1'b0;
        stop_set  = 1'b0;
        if (start_det) begin
            state_d   = ST_ADDR;
            bitcnt_d  = '0;
            ack_d     = 1'b0;
            matched_d = 1'b0;
        end else if (stop_det && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            ack_d     = 1'b0;
            stop_set  = matched_q;
            matched_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_DATA: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte[6:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == slv_addr_q && !rx_byte[0] && en_q) begin
                                    state_d   = ST_ADDR_ACK;
                                    matched_d = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (!fifo_full) begin
                                fifo_push = 1'b1;
                                state_d   = ST_DATA_ACK;
                            end else begin
                                ovf_set = 1'b1;
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // First fall opens the ACK slot, second fall closes it.
                    if (scl_fall) begin
                        if (!ack_q) begin
                            ack_d = 1'b1;
                        end else begin
                            ack_d    = 1'b0;
                            state_d  = ST_DATA;
                            bitcnt_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe_o = ack_q;

    // ---------------- APB ----------------
    logic        wr_acc, rd_acc;
    logic [31:0] rd_mux;
    logic        unused_pwdata;

    assign wr_acc   = apb.psel_i & apb.penable_i & apb.pwrite_i;
    assign rd_acc   = apb.psel_i & apb.penable_i & ~apb.pwrite_i;
    assign fifo_pop = rd_acc && (apb.paddr_i == REG1_OFF) && !fifo_empty;
    assign unused_pwdata = ^apb.pwdata_i[31:8];

    // Register writes, sticky status flags (set wins over W1C) and registered IRQ.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slv_addr_q  <= '0;
            en_q        <= 1'b0;
            irq_en_q    <= '0;
            ovf_q       <= 1'b0;
            stop_seen_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_acc && apb.paddr_i == REG0_OFF) {en_q, slv_addr_q} <= apb.pwdata_i[7:0];
            if (wr_acc && apb.paddr_i == REG3_OFF) irq_en_q <= apb.pwdata_i[1:0];
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (wr_acc && apb.paddr_i == REG2_OFF && apb.pwdata_i[R2_OVF])
                ovf_q <= 1'b0;
            if (stop_set)
                stop_seen_q <= 1'b1;
            else if (wr_acc && apb.paddr_i == REG2_OFF && apb.pwdata_i[R2_STOP])
                stop_seen_q <= 1'b0;
            irq_q <= (irq_en_q[0] & rx_not_empty) | (irq_en_q[1] & stop_seen_q);
        end
    end

    // Read mux; data is presented combinationally during the ACCESS phase.
    always_comb begin
        rd_mux = '0;
        case (apb.paddr_i)
            REG0_OFF: rd_mux = {24'b0, en_q, slv_addr_q};
            REG1_OFF: if (!fifo_empty) rd_mux = {24'b0, fifo_rdata};
            REG2_OFF: rd_mux = {27'b0, (state_q != ST_IDLE), stop_seen_q, ovf_q,
                                fifo_full, rx_not_empty};
            REG3_OFF: rd_mux = {30'b0, irq_en_q};
            default: ;
        endcase
    end

    assign apb.prdata_o  = rd_acc ? rd_mux : 32'b0;
    assign apb.pready_o  = 1'b1;
    assign apb.pslverr_o = 1'b0;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_pms_i2c_slv_irq.sv
// Directed bench for pms_i2c_slv_irq: register table plus I2C bus sequences.
module tb_pms_i2c_slv_irq;
    localparam int Q = 8;  // SoC clocks per quarter SCL period

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic sda_oe, irq, sda_line;

    int total = 0;
    int bad   = 0;

    pms_i2c_slv_irq_if apb_if();

    assign sda_line = sda_m & ~sda_oe;

    pms_i2c_slv_irq #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .apb      (apb_if),
        .scl_i    (scl),
        .sda_i    (sda_line),
        .sda_oe_o (sda_oe),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b1;
        apb_if.paddr_i = a; apb_if.pwdata_i = d;
        @(negedge clk);
        apb_if.penable_i = 1'b1;
        @(negedge clk);
        apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
        apb_if.paddr_i = a;
        @(negedge clk);
        apb_if.penable_i = 1'b1;
        #1 d = apb_if.prdata_o;
        @(negedge clk);
        apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        chk(nm, d, exp);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qw();
        scl = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qw();
        scl = 1'b1; qw();
        sda_m = 1'b1; qw();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; qw();
        scl = 1'b1; qw(); qw();
        scl = 1'b0; qw();
    endtask

    // Eight data bits then the ACK slot; ack = slave pulling the line low mid-high.
    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; qw();
        scl = 1'b1; qw();
        ack = ~sda_line;
        qw();
        scl = 1'b0; qw();
    endtask

    task automatic byte_chk(input string nm, input logic [7:0] b, input logic exp_ack);
        logic a;
        send_byte(b, a);
        chk(nm, {31'b0, a}, {31'b0, exp_ack});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        apb_if.paddr_i = '0; apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0;
        apb_if.pwrite_i = 1'b0; apb_if.pwdata_i = '0;

        vt[0]  = '{4'h0, 1'b0, 32'h0,        32'h0};
        vt[1]  = '{4'h4, 1'b0, 32'h0,        32'h0};
        vt[2]  = '{4'h8, 1'b0, 32'h0,        32'h0};
        vt[3]  = '{4'hC, 1'b0, 32'h0,        32'h0};
        vt[4]  = '{4'h0, 1'b1, 32'hFFFFFFFF, 32'h0};
        vt[5]  = '{4'h0, 1'b0, 32'h0,        32'hFF};
        vt[6]  = '{4'hC, 1'b1, 32'hFFFFFFFF, 32'h0};
        vt[7]  = '{4'hC, 1'b0, 32'h0,        32'h3};
        vt[8]  = '{4'h8, 1'b1, 32'hFF,       32'h0};
        vt[9]  = '{4'h8, 1'b0, 32'h0,        32'h0};
        vt[10] = '{4'h0, 1'b1, 32'hD0,       32'h0};
        vt[11] = '{4'h0, 1'b0, 32'h0,        32'hD0};
        vt[12] = '{4'hC, 1'b1, 32'h1,        32'h0};
        vt[13] = '{4'hC, 1'b0, 32'h0,        32'h1};

        repeat (3) @(negedge clk);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_oe", {31'b0, sda_oe}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].wr) apb_write(vt[i].addr, vt[i].data);
            else begin
                apb_read(vt[i].addr, d);
                chk($sformatf("tbl%0d", i), d, vt[i].exp);
            end
        end
        chk("idle_irq", {31'b0, irq}, 32'h0);
        chk("idle_oe", {31'b0, sda_oe}, 32'h0);

        // Basic write transaction, rx irq enabled.
        i2c_start();
        byte_chk("a_addr_ack", 8'hA0, 1'b1);
        byte_chk("a_b0_ack", 8'h11, 1'b1);
        chk("a_oe_released", {31'b0, sda_oe}, 32'h0);
        byte_chk("a_b1_ack", 8'h22, 1'b1);
        i2c_stop();
        repeat (4) @(negedge clk);
        chk("a_irq", {31'b0, irq}, 32'h1);
        rd_chk("a_reg2", 4'h8, 32'h09);
        rd_chk("a_rx0", 4'h4, 32'h11);
        chk("a_irq_mid", {31'b0, irq}, 32'h1);
        rd_chk("a_rx1", 4'h4, 32'h22);
        repeat (2) @(negedge clk);
        chk("a_irq_fall", {31'b0, irq}, 32'h0);
        rd_chk("a_rx_empty", 4'h4, 32'h0);
        apb_write(4'h8, 32'h8);
        rd_chk("a_reg2_clr", 4'h8, 32'h0);

        // Wrong address and read direction are both NACKed.
        i2c_start();
        byte_chk("b_addr_nack", 8'hA2, 1'b0);
        byte_chk("b_data_nack", 8'h33, 1'b0);
        i2c_stop();
        i2c_start();
        byte_chk("b_rd_nack", 8'hA1, 1'b0);
        byte_chk("b_rd_data_nack", 8'h44, 1'b0);
        i2c_stop();
        repeat (4) @(negedge clk);
        rd_chk("b_reg2", 4'h8, 32'h0);

        // Overflow: ninth byte NACKed and dropped.
        i2c_start();
        byte_chk("c_addr_ack", 8'hA0, 1'b1);
        for (int i = 0; i < 8; i++) byte_chk($sformatf("c_b%0d_ack", i), 8'h80 + 8'(i), 1'b1);
        byte_chk("c_b8_nack", 8'h88, 1'b0);
        i2c_stop();
        repeat (4) @(negedge clk);
        rd_chk("c_reg2", 4'h8, 32'h0F);
        apb_write(4'h8, 32'h4);
        rd_chk("c_reg2_w1c", 4'h8, 32'h0B);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("c_rx%0d", i), 4'h4, 32'h80 + i);
        rd_chk("c_reg2_drained", 4'h8, 32'h08);
        apb_write(4'h8, 32'h8);

        // Stop interrupt.
        apb_write(4'hC, 32'h2);
        i2c_start();
        byte_chk("d_addr_ack", 8'hA0, 1'b1);
        byte_chk("d_b0_ack", 8'h5A, 1'b1);
        i2c_stop();
        repeat (4) @(negedge clk);
        chk("d_irq", {31'b0, irq}, 32'h1);
        rd_chk("d_reg2", 4'h8, 32'h09);
        apb_write(4'h8, 32'h8);
        repeat (2) @(negedge clk);
        chk("d_irq_clr", {31'b0, irq}, 32'h0);
        rd_chk("d_reg2_clr", 4'h8, 32'h01);
        rd_chk("d_rx0", 4'h4, 32'h5A);

        // Repeated START mid-stream.
        apb_write(4'hC, 32'h0);
        i2c_start();
        rd_chk("e_busy", 4'h8, 32'h10);
        byte_chk("e_addr_ack", 8'hA0, 1'b1);
        byte_chk("e_b0_ack", 8'h01, 1'b1);
        byte_chk("e_b1_ack", 8'h02, 1'b1);
        i2c_start();
        byte_chk("e_raddr_ack", 8'hA0, 1'b1);
        byte_chk("e_b2_ack", 8'h03, 1'b1);
        i2c_stop();
        repeat (4) @(negedge clk);
        rd_chk("e_reg2", 4'h8, 32'h09);
        rd_chk("e_rx0", 4'h4, 32'h01);
        rd_chk("e_rx1", 4'h4, 32'h02);
        rd_chk("e_rx2", 4'h4, 32'h03);
        apb_write(4'h8, 32'h8);

        // Reset in the middle of a data ACK slot.
        i2c_start();
        byte_chk("f_addr_ack", 8'hA0, 1'b1);
        for (int i = 7; i >= 0; i--) send_bit(1'b0);
        sda_m = 1'b1;
        qw();
        chk("f_oe_ack", {31'b0, sda_oe}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("f_oe_rst", {31'b0, sda_oe}, 32'h0);
        rd_chk("f_reg2_rst", 4'h8, 32'h0);
        rd_chk("f_reg0_rst", 4'h0, 32'h0);
        scl = 1'b1; qw();
        i2c_stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
